// File: rtl/sincos_pkg.sv
// Shared constants and helpers for the sine/cosine DDS: quarter-wave table generator and quadrant folding.
// Latency: n/a (elaboration-time constants and pure combinational helpers).
// Backpressure: n/a.
package sincos_pkg;

    localparam int PHASE_W_DEF = 16;
    localparam int ADDR_W_DEF  = 8;
    localparam int OUT_W_DEF   = 9;
    localparam int N           = 1 << ADDR_W_DEF;
    localparam int AMP         = (1 << (OUT_W_DEF - 1)) - 1;

    localparam real HALF_PI = 1.5707963267948966;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    // Half-sample offset keeps the table mirror-exact, so Q[~i] is the reflected angle.
    function automatic int sincos_q(input int i, input int addr_w, input int out_w);
        real n_ent;
        real amp;
        n_ent = real'(1 << addr_w);
        amp   = real'((1 << (out_w - 1)) - 1);
        return $rtoi(amp * $sin(HALF_PI * (real'(i) + 0.5) / n_ent) + 0.5);
    endfunction

    function automatic logic sin_mirror(input quad_e q);
        logic [1:0] b;
        b = q;
        return b[0];
    endfunction

    function automatic logic sin_negate(input quad_e q);
        logic [1:0] b;
        b = q;
        return b[1];
    endfunction

    function automatic logic cos_mirror(input quad_e q);
        logic [1:0] b;
        b = q;
        return ~b[0];
    endfunction

    function automatic logic cos_negate(input quad_e q);
        logic [1:0] b;
        b = q;
        return b[1] ^ b[0];
    endfunction

endpackage

// File: rtl/sincos_quarter_rom.sv
// Quarter-wave magnitude table with two independent synchronous read ports (sin and cos).
// Latency: 1 cycle, output registered and loaded only when rd_en=1 (holds otherwise).
// Backpressure: none; accepts a read every cycle.
import sincos_pkg::*;

module sincos_quarter_rom #(
    parameter int ADDR_W = 8,
    parameter int OUT_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] sin_addr,
    input  logic [ADDR_W-1:0] cos_addr,
    output logic [OUT_W-2:0]  sin_mag,
    output logic [OUT_W-2:0]  cos_mag
);

    localparam int MAG_W = OUT_W - 1;
    localparam int N_ENT = 1 << ADDR_W;

    logic [MAG_W-1:0] table_w [N_ENT];
    logic [MAG_W-1:0] sin_mag_q;
    logic [MAG_W-1:0] sin_mag_d;
    logic [MAG_W-1:0] cos_mag_q;
    logic [MAG_W-1:0] cos_mag_d;

    for (genvar g = 0; g < N_ENT; g++) begin : g_tab
        assign table_w[g] = MAG_W'(sincos_q(g, ADDR_W, OUT_W));
    end

    always_comb begin
        sin_mag_d = sin_mag_q;
        cos_mag_d = cos_mag_q;
        if (rd_en) begin
            sin_mag_d = table_w[sin_addr];
            cos_mag_d = table_w[cos_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_mag_q <= '0;
            cos_mag_q <= '0;
        end else begin
            sin_mag_q <= sin_mag_d;
            cos_mag_q <= cos_mag_d;
        end
    end

    assign sin_mag = sin_mag_q;
    assign cos_mag = cos_mag_q;

endmodule

// File: rtl/sincos_dds.sv
// DDS sine/cosine generator: phase accumulator, quadrant fold, quarter ROM, sign restore.
// Latency: 3 edges from the launch edge (en=1) to out_valid with matching data.
// Backpressure: none; one sample per cycle, outputs hold while out_valid=0.
import sincos_pkg::*;

module sincos_dds #(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 8,
    parameter int OUT_W   = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [PHASE_W-1:0] phase_off,
    output logic [OUT_W-1:0]   sin_out,
    output logic [OUT_W-1:0]   cos_out,
    output logic               out_valid
);

    localparam int MAG_W = OUT_W - 1;
    localparam int LSB_W = PHASE_W - 2 - ADDR_W;

    logic [PHASE_W-1:0] acc_q;
    logic [PHASE_W-1:0] acc_d;
    logic [PHASE_W-1:0] launch_p;

    logic               s1_vld_q;
    logic               s1_vld_d;
    logic [PHASE_W-1:0] s1_p_q;
    logic [PHASE_W-1:0] s1_p_d;

    quad_e              quad;
    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W-1:0]  sin_addr;
    logic [ADDR_W-1:0]  cos_addr;

    logic               s2_vld_q;
    logic               s2_vld_d;
    logic               s2_sin_neg_q;
    logic               s2_sin_neg_d;
    logic               s2_cos_neg_q;
    logic               s2_cos_neg_d;
    logic [MAG_W-1:0]   sin_mag;
    logic [MAG_W-1:0]   cos_mag;
    logic [OUT_W-1:0]   sin_ext;
    logic [OUT_W-1:0]   cos_ext;

    logic               out_vld_q;
    logic               out_vld_d;
    logic [OUT_W-1:0]   sin_q;
    logic [OUT_W-1:0]   sin_d;
    logic [OUT_W-1:0]   cos_q;
    logic [OUT_W-1:0]   cos_d;

    // Launch uses the pre-update accumulator, so clr+en still emits the old phase.
    always_comb begin
        launch_p = acc_q + phase_off;
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + freq_word;
        end
        s1_vld_d = en;
        s1_p_d   = en ? launch_p : s1_p_q;
    end

    always_comb begin
        quad     = quad_e'(s1_p_q[PHASE_W-1 -: 2]);
        idx      = s1_p_q[PHASE_W-3 -: ADDR_W];
        sin_addr = sin_mirror(quad) ? ~idx : idx;
        cos_addr = cos_mirror(quad) ? ~idx : idx;

        s2_vld_d     = s1_vld_q;
        s2_sin_neg_d = s2_sin_neg_q;
        s2_cos_neg_d = s2_cos_neg_q;
        if (s1_vld_q) begin
            s2_sin_neg_d = sin_negate(quad);
            s2_cos_neg_d = cos_negate(quad);
        end
    end

    if (LSB_W > 0) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^s1_p_q[LSB_W-1:0];
    end

    sincos_quarter_rom #(
        .ADDR_W (ADDR_W),
        .OUT_W  (OUT_W)
    ) u_rom (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (s1_vld_q),
        .sin_addr (sin_addr),
        .cos_addr (cos_addr),
        .sin_mag  (sin_mag),
        .cos_mag  (cos_mag)
    );

    // Magnitudes never exceed AMP, so the negation cannot overflow OUT_W.
    always_comb begin
        sin_ext   = {1'b0, sin_mag};
        cos_ext   = {1'b0, cos_mag};
        out_vld_d = s2_vld_q;
        sin_d     = sin_q;
        cos_d     = cos_q;
        if (s2_vld_q) begin
            sin_d = s2_sin_neg_q ? (~sin_ext) + OUT_W'(1) : sin_ext;
            cos_d = s2_cos_neg_q ? (~cos_ext) + OUT_W'(1) : cos_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            s1_vld_q     <= 1'b0;
            s1_p_q       <= '0;
            s2_vld_q     <= 1'b0;
            s2_sin_neg_q <= 1'b0;
            s2_cos_neg_q <= 1'b0;
            out_vld_q    <= 1'b0;
            sin_q        <= '0;
            cos_q        <= '0;
        end else begin
            acc_q        <= acc_d;
            s1_vld_q     <= s1_vld_d;
            s1_p_q       <= s1_p_d;
            s2_vld_q     <= s2_vld_d;
            s2_sin_neg_q <= s2_sin_neg_d;
            s2_cos_neg_q <= s2_cos_neg_d;
            out_vld_q    <= out_vld_d;
            sin_q        <= sin_d;
            cos_q        <= cos_d;
        end
    end

    assign sin_out   = sin_q;
    assign cos_out   = cos_q;
    assign out_valid = out_vld_q;

endmodule

// File: tb/tb_sincos_dds.sv
// Directed bench for sincos_dds: quadrant points, sweep, wrap/offset, clr+en, en gaps, async reset.
module tb_sincos_dds;

    localparam real PI = 3.14159265358979;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              clr;
    logic [15:0]       freq_word;
    logic [15:0]       phase_off;
    logic signed [8:0] sin_out;
    logic signed [8:0] cos_out;
    logic              out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_acc;
    logic        m1_vld;
    logic [15:0] m1_p;
    logic        m2_vld;
    int          m2_s;
    int          m2_c;
    logic        mo_vld;
    int          mo_s;
    int          mo_c;

    int cap_s[$];
    int cap_c[$];

    int q_vld[7]   = '{0, 0, 1, 1, 1, 1, 0};
    int q_sin[4]   = '{1, 255, -1, -255};
    int q_cos[4]   = '{255, -1, -255, 1};
    int g_en[8]    = '{1, 0, 1, 1, 0, 0, 0, 0};
    int g_vld[8]   = '{0, 0, 1, 0, 1, 1, 0, 0};

    sincos_dds dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .freq_word (freq_word),
        .phase_off (phase_off),
        .sin_out   (sin_out),
        .cos_out   (cos_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int q_tab(input int i);
        return $rtoi(255.0 * $sin(PI / 2.0 * (real'(i) + 0.5) / 256.0) + 0.5);
    endfunction

    function automatic int m_sin(input logic [15:0] p);
        int i;
        i = int'(p[13:6]);
        case (p[15:14])
            2'd0:    return q_tab(i);
            2'd1:    return q_tab(255 - i);
            2'd2:    return -q_tab(i);
            default: return -q_tab(255 - i);
        endcase
    endfunction

    function automatic int m_cos(input logic [15:0] p);
        logic [15:0] t;
        t = p + 16'h4000;
        return m_sin(t);
    endfunction

    task automatic model_reset();
        m_acc  = '0;
        m1_vld = 1'b0;
        m1_p   = '0;
        m2_vld = 1'b0;
        m2_s   = 0;
        m2_c   = 0;
        mo_vld = 1'b0;
        mo_s   = 0;
        mo_c   = 0;
    endtask

    // One clock: drive en/clr, advance the reference pipeline, check outputs 1 time unit after the edge.
    task automatic cyc(input logic e, input logic c);
        en  = e;
        clr = c;
        @(posedge clk);
        if (m2_vld) begin
            mo_s = m2_s;
            mo_c = m2_c;
        end
        mo_vld = m2_vld;
        if (m1_vld) begin
            m2_s = m_sin(m1_p);
            m2_c = m_cos(m1_p);
        end
        m2_vld = m1_vld;
        if (e) m1_p = m_acc + phase_off;
        m1_vld = e;
        if (c) m_acc = '0;
        else if (e) m_acc = m_acc + freq_word;
        #1;
        check_val("out_valid", int'(out_valid), int'(mo_vld));
        check_val("sin_out", int'(sin_out), mo_s);
        check_val("cos_out", int'(cos_out), mo_c);
        if (out_valid) begin
            cap_s.push_back(int'(sin_out));
            cap_c.push_back(int'(cos_out));
        end
    endtask

    task automatic clear_caps();
        cap_s.delete();
        cap_c.delete();
    endtask

    initial begin
        int e;
        rst_n     = 1'b0;
        en        = 1'b0;
        clr       = 1'b0;
        freq_word = '0;
        phase_off = '0;
        model_reset();

        // reset state before any edge
        #3;
        check_val("rst_sin", int'(sin_out), 0);
        check_val("rst_cos", int'(cos_out), 0);
        check_val("rst_vld", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // quadrant points
        freq_word = 16'h4000;
        phase_off = 16'h0000;
        clear_caps();
        for (int k = 1; k <= 7; k++) begin
            cyc(k <= 4, 1'b0);
            check_val("quad_vld", int'(out_valid), q_vld[k-1]);
        end
        check_val("quad_count", cap_s.size(), 4);
        if (cap_s.size() == 4) begin
            for (int j = 0; j < 4; j++) begin
                check_val("quad_sin", cap_s[j], q_sin[j]);
                check_val("quad_cos", cap_c[j], q_cos[j]);
            end
        end

        // full-turn sweep
        freq_word = 16'h0040;
        cyc(1'b0, 1'b1);
        clear_caps();
        for (int k = 0; k < 1024; k++) cyc(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0);
        check_val("sweep_count", cap_s.size(), 1024);
        if (cap_s.size() == 1024) begin
            for (int n = 0; n < 512; n++) check_val("sweep_half", cap_s[n+512], -cap_s[n]);
            for (int n = 0; n < 256; n++) check_val("sweep_mirror", cap_s[511-n], cap_s[n]);
            for (int n = 0; n < 1024; n++) begin
                e = cap_s[n] * cap_s[n] + cap_c[n] * cap_c[n] - 255 * 255;
                check_val("sweep_power", int'(e <= 510 && e >= -510), 1);
            end
        end

        // accumulator wrap and 270 degree offset
        freq_word = 16'h0000;
        phase_off = 16'h0000;
        cyc(1'b0, 1'b1);
        clear_caps();
        freq_word = 16'hFFC0;
        cyc(1'b1, 1'b0);
        freq_word = 16'h0080;
        cyc(1'b1, 1'b0);
        freq_word = 16'h0900;
        phase_off = 16'hC000;
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0);
        check_val("wrap_count", cap_s.size(), 8);
        if (cap_s.size() == 8) begin
            check_val("wrap_sin_ffc0", cap_s[1], -1);
            check_val("wrap_cos_ffc0", cap_c[1], 255);
            check_val("off_sin_c040", cap_s[2], -255);
            check_val("off_cos_c040", cap_c[2], 2);
            for (int j = 2; j < 8; j++) begin
                check_val("off_sin_270", cap_s[j], -m_cos(16'h0040 + 16'(j - 2) * 16'h0900));
            end
        end

        // clr and en on the same edge
        phase_off = 16'h0000;
        cyc(1'b0, 1'b1);
        clear_caps();
        freq_word = 16'h1234;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        phase_off = 16'h2000;
        cyc(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0);
        check_val("clr_count", cap_s.size(), 3);
        if (cap_s.size() == 3) begin
            check_val("clr_sin_1234", cap_s[1], 110);
            check_val("clr_cos_1234", cap_c[1], 230);
            check_val("clr_sin_off", cap_s[2], 181);
            check_val("clr_cos_off", cap_c[2], 180);
        end

        // en gaps: valid follows en delayed, data holds in the gaps
        freq_word = 16'h1000;
        phase_off = 16'h0000;
        cyc(1'b0, 1'b1);
        clear_caps();
        for (int k = 1; k <= 8; k++) begin
            cyc(g_en[k-1] != 0, 1'b0);
            check_val("gap_vld", int'(out_valid), g_vld[k-1]);
            if (k == 4) begin
                check_val("gap_hold_sin", int'(sin_out), 1);
                check_val("gap_hold_cos", int'(cos_out), 255);
            end
        end
        check_val("gap_count", cap_s.size(), 3);
        if (cap_s.size() == 3) begin
            check_val("gap_sin_last", cap_s[2], 181);
            check_val("gap_cos_last", cap_c[2], 180);
        end

        // asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_sin", int'(sin_out), 0);
        check_val("arst_cos", int'(cos_out), 0);
        check_val("arst_vld", int'(out_valid), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        freq_word = 16'h4000;
        clear_caps();
        cyc(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0);
        check_val("arst_count", cap_s.size(), 1);
        if (cap_s.size() == 1) begin
            check_val("arst_sin_p0", cap_s[0], 1);
            check_val("arst_cos_p0", cap_c[0], 255);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
